// File: rtl/cpu_pipe_pkg.sv
// Shared types and defaults for CPU pipeline stage registers.
package cpu_pipe_pkg;
   typedef logic [1:0] pipe_occ_t;
   localparam int PIPE_DATA_W_DEF = 64;
endpackage

// File: rtl/pipe_slot.sv
// One valid+payload holding register. clear kills valid and payload,
// consume drops valid only, load captures dIn. Priority: clear, load, consume.
module pipe_slot #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load,
   input  logic              consume,
   input  logic [DATA_W-1:0] dIn,
   output logic              valid,
   output logic [DATA_W-1:0] data
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= dIn;
      end else if (consume) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, flush, optional skid
// entry for a registered in_ready, occupancy report and saturating stall counter.
module pipe_stage_skid
   import cpu_pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W_DEF,
   parameter bit SKID   = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output pipe_occ_t         occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);
   logic              mainV, skidV;
   logic [DATA_W-1:0] mainD, skidD, mainDin;
   logic              mainLoad, mainConsume, skidLoad, skidConsume;
   logic              inFire, outFire;

   assign out_valid = mainV && !flush;
   assign out_data  = mainD;
   assign in_ready  = SKID ? (!skidV && !flush) : ((!mainV || out_ready) && !flush);
   assign inFire    = in_valid && in_ready;
   assign outFire   = out_valid && out_ready;
   assign occupancy = pipe_occ_t'({1'b0, mainV}) + pipe_occ_t'({1'b0, skidV});

   always_comb begin
      mainLoad    = 1'b0;
      mainConsume = 1'b0;
      mainDin     = in_data;
      skidLoad    = 1'b0;
      skidConsume = 1'b0;
      if (flush) begin
         // slots clear themselves on flush
      end else if (SKID) begin
         if (outFire) begin
            // skid is always older than any incoming beat, so it drains first
            if (skidV) begin
               mainLoad    = 1'b1;
               mainDin     = skidD;
               skidConsume = 1'b1;
            end else if (inFire) begin
               mainLoad = 1'b1;
            end else begin
               mainConsume = 1'b1;
            end
         end else if (inFire) begin
            if (!mainV) mainLoad = 1'b1;
            else        skidLoad = 1'b1;
         end
      end else begin
         if (inFire)       mainLoad    = 1'b1;
         else if (outFire) mainConsume = 1'b1;
      end
   end

   pipe_slot #(.DATA_W(DATA_W)) uMain (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (flush),
      .load    (mainLoad),
      .consume (mainConsume),
      .dIn     (mainDin),
      .valid   (mainV),
      .data    (mainD)
   );

   generate
      if (SKID) begin : genSkid
         pipe_slot #(.DATA_W(DATA_W)) uSkid (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (flush),
            .load    (skidLoad),
            .consume (skidConsume),
            .dIn     (in_data),
            .valid   (skidV),
            .data    (skidD)
         );
      end else begin : genNoSkid
         assign skidV = 1'b0;
         assign skidD = '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
         stall_cnt <= stall_cnt + 1'b1;
   end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: SKID=1, SKID=0 and CNT_W=4 instances share one input stream.
module tb_pipe_stage_skid;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] in_data = '0;

   logic       inReady1, outValid1, inReady0, outValid0, inReady4, outValid4;
   logic [7:0] outData1, outData0, outData4;
   logic [1:0] occ1, occ0, occ4;
   logic [15:0] stall1, stall0;
   logic [3:0]  stall4;

   int nTests = 0;
   int nFail  = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(8), .SKID(1'b1), .CNT_W(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(inReady1),
      .in_data(in_data), .out_valid(outValid1), .out_ready(out_ready), .out_data(outData1),
      .occupancy(occ1), .stall_cnt(stall1));

   pipe_stage_skid #(.DATA_W(8), .SKID(1'b0), .CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(inReady0),
      .in_data(in_data), .out_valid(outValid0), .out_ready(out_ready), .out_data(outData0),
      .occupancy(occ0), .stall_cnt(stall0));

   pipe_stage_skid #(.DATA_W(8), .SKID(1'b1), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(inReady4),
      .in_data(in_data), .out_valid(outValid4), .out_ready(out_ready), .out_data(outData4),
      .occupancy(occ4), .stall_cnt(stall4));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      #3;
      chk("rst outValid", 32'(outValid1), 0);
      chk("rst outData", 32'(outData1), 0);
      chk("rst occ", 32'(occ1), 0);
      chk("rst stall", 32'(stall1), 0);
      rst_n = 1'b1;
      #1;
      chk("rst inReady1", 32'(inReady1), 1);
      chk("rst inReady0", 32'(inReady0), 1);

      // single beat
      in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      chk("single outValid", 32'(outValid1), 1);
      chk("single outData", 32'(outData1), 32'hA5);
      chk("single occ", 32'(occ1), 1);
      chk("single outData0", 32'(outData0), 32'hA5);
      tick();
      chk("single occ drained", 32'(occ1), 0);
      chk("single outValid drained", 32'(outValid1), 0);

      // back-to-back into a blocked stage
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h01;
      tick();
      in_data = 8'h02;
      tick();
      in_valid = 1'b0;
      #1;
      chk("full occ", 32'(occ1), 2);
      chk("full inReady", 32'(inReady1), 0);
      tick(); tick(); tick();
      chk("blocked stall1", 32'(stall1), 4);
      chk("blocked stall0", 32'(stall0), 4);
      chk("blocked head", 32'(outData1), 32'h01);
      out_ready = 1'b1;
      #1;
      chk("pop1 outValid", 32'(outValid1), 1);
      chk("pop1 data", 32'(outData1), 32'h01);
      tick();
      chk("pop2 data", 32'(outData1), 32'h02);
      chk("pop2 occ", 32'(occ1), 1);
      chk("pop2 inReady", 32'(inReady1), 1);
      tick();
      chk("drain occ", 32'(occ1), 0);
      chk("drain stall1 kept", 32'(stall1), 4);

      // streaming at full rate
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1; in_data = 8'(i);
         #1;
         chk("stream inReady1", 32'(inReady1), 1);
         chk("stream inReady0", 32'(inReady0), 1);
         tick();
         chk("stream data1", 32'(outValid1 ? outData1 : 8'hFF), 32'(i));
         chk("stream data0", 32'(outValid0 ? outData0 : 8'hFF), 32'(i));
         chk("stream occ1", 32'(occ1), 1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream end occ1", 32'(occ1), 0);
      chk("stream end occ0", 32'(occ0), 0);

      // flush while full with a beat offered
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h10;
      tick();
      in_data = 8'h11;
      tick();
      chk("pre-flush occ", 32'(occ1), 2);
      flush = 1'b1; in_data = 8'h07;
      #1;
      chk("flush outValid", 32'(outValid1), 0);
      chk("flush inReady", 32'(inReady1), 0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("post-flush occ", 32'(occ1), 0);
      chk("post-flush outData", 32'(outData1), 0);
      chk("post-flush outValid", 32'(outValid1), 0);
      chk("post-flush occ0", 32'(occ0), 0);
      tick();
      chk("no 0x7 outValid", 32'(outValid1), 0);
      chk("flush keeps stall", 32'(stall1), 5);

      // saturation on the 4-bit counter
      in_valid = 1'b1; in_data = 8'h33;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("sat stall4", 32'(stall4), 15);
      chk("wide stall1", 32'(stall1), 25);
      tick();
      chk("sat hold stall4", 32'(stall4), 15);

      // async reset mid-cycle while full
      in_valid = 1'b1; in_data = 8'h22;
      tick();
      in_valid = 1'b0;
      #1;
      chk("pre-rst occ", 32'(occ1), 2);
      rst_n = 1'b0;
      #1;
      chk("async outValid", 32'(outValid1), 0);
      chk("async outData", 32'(outData1), 0);
      chk("async occ", 32'(occ1), 0);
      chk("async stall1", 32'(stall1), 0);
      chk("async stall4", 32'(stall4), 0);
      rst_n = 1'b1;
      #1;
      chk("async inReady", 32'(inReady1), 1);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
